// File: rtl/queue_pkg.sv
// Shared helpers for the queue FIFO: modulo pointer advance for any depth.
package queue_pkg;

   // Advance a pointer by one, wrapping at depth (no power-of-2 assumption).
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/queue_mem.sv
// DEPTH x WL register array with one write port and a registered read port.
module queue_mem #(
   parameter int unsigned WL    = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [WL-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [WL-1:0] rdata
);

   logic [WL-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read sees the pre-write contents, so a same-edge read/write of one slot
   // returns the oldest word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/queue.sv
// Synchronous FIFO: pointers, occupancy, status and error flag around queue_mem.
module queue
   import queue_pkg::*;
#(
   parameter int unsigned WL    = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          rReq,
   input  logic          wReq,
   input  logic [WL-1:0] din,
   output logic [WL-1:0] dout,
   output logic          FULL,
   output logic          EMPTY,
   output logic          ERROR
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          error_q, error_d;
   logic          wr_ok, rd_ok;

   assign FULL  = (count_q == CW'(DEPTH));
   assign EMPTY = (count_q == '0);
   assign ERROR = error_q;

   always_comb begin
      wr_ok   = wReq && (!FULL || rReq);
      rd_ok   = rReq && !EMPTY;
      error_d = (wReq && FULL && !rReq) || (rReq && EMPTY);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_ok) begin
         wptr_d = PW'(ptr_inc(32'(wptr_q), DEPTH));
      end
      if (rd_ok) begin
         rptr_d = PW'(ptr_inc(32'(rptr_q), DEPTH));
      end
      if (wr_ok && !rd_ok) begin
         count_d = count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   queue_mem #(
      .WL    (WL),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (CLK),
      .rst   (RST),
      .we    (wr_ok && !RST),
      .waddr (wptr_q),
      .wdata (din),
      .re    (rd_ok && !RST),
      .raddr (rptr_q),
      .rdata (dout)
   );

endmodule

// File: tb/tb_queue.sv
// Randomized and directed check of queue against a queue-based FIFO model.
module tb_queue;

   localparam int unsigned WL    = 4;
   localparam int unsigned DEPTH = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          rReq = 1'b0;
   logic          wReq = 1'b0;
   logic [WL-1:0] din = '0;
   logic [WL-1:0] dout;
   logic          FULL, EMPTY, ERROR;

   int n_total  = 0;
   int n_passed = 0;

   // Reference model state after the most recent edge.
   int unsigned   mq[$];
   logic [WL-1:0] m_dout = '0;
   logic          m_err  = 1'b0;

   queue #(
      .WL    (WL),
      .DEPTH (DEPTH)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .rReq  (rReq),
      .wReq  (wReq),
      .din   (din),
      .dout  (dout),
      .FULL  (FULL),
      .EMPTY (EMPTY),
      .ERROR (ERROR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model of one clock edge, from the FIFO's rules.
   task automatic model_step(input logic r, input logic w, input logic rst,
                             input logic [WL-1:0] d);
      bit full, empty;
      if (rst) begin
         mq.delete();
         m_dout = '0;
         m_err  = 1'b0;
         return;
      end
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      m_err = (w && full && !r) || (r && empty);
      if (r && !empty) begin
         m_dout = WL'(mq.pop_front());
      end
      if (w && (!full || r)) begin
         mq.push_back(int'(d));
      end
   endtask

   // Drive one cycle, let the edge pass, then compare at the falling edge.
   task automatic cycle(input logic rst, input logic r, input logic w, input logic [WL-1:0] d);
      RST  = rst;
      rReq = r;
      wReq = w;
      din  = d;
      model_step(r, w, rst, d);
      @(negedge CLK);
      check("EMPTY", 32'(EMPTY), 32'(mq.size() == 0));
      check("FULL",  32'(FULL),  32'(mq.size() == DEPTH));
      check("ERROR", 32'(ERROR), 32'(m_err));
      check("dout",  32'(dout),  32'(m_dout));
   endtask

   initial begin
      // Reset
      cycle(1, 0, 0, 0);
      // Fill, then overflow twice
      cycle(0, 0, 1, 4'd1);
      cycle(0, 0, 1, 4'd2);
      cycle(0, 0, 1, 4'd4);
      cycle(0, 0, 1, 4'd5);
      check("full_after_4", 32'(FULL), 32'd1);
      cycle(0, 0, 1, 4'd7);
      check("ovf_err1", 32'(ERROR), 32'd1);
      cycle(0, 0, 1, 4'd4);
      check("ovf_err2", 32'(ERROR), 32'd1);
      // Read while full, refill, overflow
      cycle(0, 1, 0, 0);
      check("first_out", 32'(dout), 32'd1);
      cycle(0, 0, 1, 4'd3);
      cycle(0, 0, 1, 4'd1);
      check("ovf_err3", 32'(ERROR), 32'd1);
      // Drain, underflow, write
      cycle(0, 1, 0, 0);
      check("drain0", 32'(dout), 32'd2);
      cycle(0, 1, 0, 0);
      check("drain1", 32'(dout), 32'd4);
      cycle(0, 1, 0, 0);
      check("drain2", 32'(dout), 32'd5);
      cycle(0, 1, 0, 0);
      check("drain3", 32'(dout), 32'd3);
      check("empty_after_drain", 32'(EMPTY), 32'd1);
      cycle(0, 1, 0, 0);
      check("udf_err", 32'(ERROR), 32'd1);
      check("udf_hold", 32'(dout), 32'd3);
      cycle(0, 0, 1, 4'd2);
      check("not_empty", 32'(EMPTY), 32'd0);
      // Fill, then simultaneous read/write while full across the wrap
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, WL'(8 + i));
      for (int i = 0; i < 7; i++) begin
         cycle(0, 1, 1, WL'(i + 3));
         check("full_hold", 32'(FULL), 32'd1);
      end
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
      // Simultaneous while empty: write only, error
      cycle(0, 1, 1, 4'd9);
      check("empty_rw_err", 32'(ERROR), 32'd1);
      // Reset mid-operation with 3 words
      cycle(0, 0, 1, 4'd6);
      cycle(0, 0, 1, 4'd7);
      cycle(1, 0, 0, 0);
      check("rst_dout", 32'(dout), 32'd0);
      cycle(0, 1, 0, 0);
      check("rst_then_read", 32'(ERROR), 32'd1);
      // Randomized traffic, drifting write/read bias to visit full and empty
      for (int i = 0; i < 3000; i++) begin
         int unsigned bias;
         bias = ((i / 200) % 2 == 0) ? 75 : 25;
         cycle(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
               ($urandom_range(99) >= bias) ? 1'b1 : 1'b0,
               ($urandom_range(99) < bias) ? 1'b1 : 1'b0,
               WL'($urandom));
      end
      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
